rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port (Rw, Di, WE) and shares it between two writeback requesters: req0 (ALU path) and req1 (load/multicycle path).
- After reset, runs a clear sequence that writes zero to registers 1..NREG-1.
- Then arbitrates valid/ready writeback requests onto the port with 1-cycle registered latency.
- Sits between the writeback stage and RFile.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- NREG, 32, number of architectural registers; register 0 is hardwired zero

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_rw  input  ADDR_W  requester 0 destination register
- req0_di  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 transfer accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_rw  input  ADDR_W  requester 1 destination register
- req1_di  input  DATA_W  requester 1 write data
- req1_ready  output  1  requester 1 transfer accepted this cycle
- Rw  output  ADDR_W  RF write address (registered)
- Di  output  DATA_W  RF write data (registered)
- WE  output  1  RF write enable (registered)
- busy  output  1  clear sequence in progress (registered)
- grant  output  1  index of the last accepted requester (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - WE=0, Rw=0, Di=0, busy=1, grant=0.
  - State=CLEAR, clear counter=1.
  - Round-robin pointer (if present) favours req0.
- States: CLEAR, RUN. CLEAR is entered only via reset.
- CLEAR:
  - Each rising edge drives WE=1, Rw=counter, Di=0, then increments counter.
  - On the edge that drives Rw=NREG-1, go to RUN and set busy=0.
  - The sequence takes NREG-1 edges after reset release. busy=0 from edge NREG-1 onward.
  - reqN_ready=0 throughout.
- RUN:
  - reqN_ready is combinational from the valids and state.
  - At most one ready is high per cycle. A transfer occurs when valid&ready.
  - Requesters must hold valid/rw/di stable until ready; valid must not depend on ready.
  - Arbitration: fixed priority, req0 wins when both are valid.
  - A lone valid requester is always granted in the same cycle (no bubble).
- Output timing: a transfer in cycle t appears on Rw/Di/WE after the edge ending cycle t, and grant updates on that edge.
  - When no transfer occurs, the edge sets WE=0.
  - Rw/Di hold their previous values when WE=0.
- Register 0:
  - A transfer with rw==0 is accepted (ready=1, grant updated) but produces WE=0. The write is dropped.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed.
- Width: rw values ≥ NREG are not checked; the caller guarantees rw<NREG.
- Reset mid-operation:
  - Asserting reset in any state immediately forces the reset values and restarts CLEAR on release.
  - In-flight requests are neither acknowledged nor written. Requesters must re-present them.

Optional Feature:
- Macro: RFWB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer gives priority to the requester not granted last.
  - The pointer updates only on an accepted transfer, including rw==0 transfers.
  - Reset sets the pointer to favour req0.
- Undefined: fixed priority, req0 over req1. No pointer flop exists.

Test Plan:
- Release reset, no requests -> WE=1 with Rw=1,2,...,31 and Di=0 on consecutive edges; busy=1 until the edge driving Rw=31, then 0; readies low throughout; next edge WE=0.
- After CLEAR, req0_valid=1, rw=2, di=5 for one cycle -> req0_ready=1 that cycle; next edge Rw=2, Di=5, WE=1, grant=0; following edge WE=0.
- Both valid (req0 rw=3 di=7, req1 rw=4 di=9), held until accepted:
  - Fixed priority -> req0 accepted first, then req1; outputs (3,7) then (4,9) on consecutive edges.
  - With RFWB_ROUND_ROBIN_EN and both valid for 4 cycles -> grant alternates 0,1,0,1.
- req1_valid=1, rw=0, di=0xFFFFFFFF -> req1_ready=1 and grant=1, but WE stays 0.
- Assert reset during CLEAR at Rw=10 and again during RUN with req0 pending -> outputs drop immediately to WE=0, Rw=0, busy=1; on release, CLEAR restarts at Rw=1; the pending req0 is not acknowledged before busy=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Owns the single register-file write port (Rw/Di/WE) and shares it between
// two writeback requesters. After reset it first walks registers 1..NREG-1
// writing zero (CLEAR), then arbitrates valid/ready writeback requests onto
// the port with one cycle of registered latency (RUN).
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   req0_valid/rw/di    requester 0 (ALU path) write request
//   req0_ready          requester 0 transfer accepted this cycle
//   req1_valid/rw/di    requester 1 (load/multicycle path) write request
//   req1_ready          requester 1 transfer accepted this cycle
//   Rw, Di, WE          registered register-file write port
//   busy                clear sequence in progress
//   grant               index of the last accepted requester
//
// Build option:
//   RFWB_ROUND_ROBIN_EN  when defined, a 1-bit pointer gives priority to the
//                        requester not granted last; otherwise req0 always
//                        wins over req1.

module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rw,
    input  logic [DATA_W-1:0] req0_di,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rw,
    input  logic [DATA_W-1:0] req1_di,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] Di,
    output logic              WE,
    output logic              busy,
    output logic              grant
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [ADDR_W-1:0] rw_q,    rw_d;
    logic [DATA_W-1:0] di_q,    di_d;
    logic              we_q,    we_d;
    logic              busy_q,  busy_d;
    logic              grant_q, grant_d;
    logic              run;

`ifdef RFWB_ROUND_ROBIN_EN
    // ptr_q = 1 means req1 has priority on a tie (req0 was granted last).
    logic              ptr_q,   ptr_d;
`endif

    assign run = (state_q == ST_RUN);

    // Readies depend only on the valids and the state, never on each other's
    // ready, so a lone valid requester is accepted in the same cycle.
    always_comb begin
`ifdef RFWB_ROUND_ROBIN_EN
        req0_ready = run & req0_valid & (~req1_valid | ~ptr_q);
        req1_ready = run & req1_valid & (~req0_valid |  ptr_q);
`else
        req0_ready = run & req0_valid;
        req1_ready = run & req1_valid & ~req0_valid;
`endif
    end

    // Next-state logic. In CLEAR the counter drives the write port with zero
    // data; in RUN the accepted request is forwarded, except writes to
    // register 0, which are acknowledged but dropped. Rw/Di only change when
    // a real write is issued so they hold their value while WE is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        di_d    = di_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        grant_d = grant_q;
`ifdef RFWB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                we_d  = 1'b1;
                rw_d  = cnt_q;
                di_d  = '0;
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_REG) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                if (req0_ready) begin
                    grant_d = 1'b0;
`ifdef RFWB_ROUND_ROBIN_EN
                    ptr_d   = 1'b1;
`endif
                    if (req0_rw != '0) begin
                        we_d = 1'b1;
                        rw_d = req0_rw;
                        di_d = req0_di;
                    end
                end else if (req1_ready) begin
                    grant_d = 1'b1;
`ifdef RFWB_ROUND_ROBIN_EN
                    ptr_d   = 1'b0;
`endif
                    if (req1_rw != '0) begin
                        we_d = 1'b1;
                        rw_d = req1_rw;
                        di_d = req1_di;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset restarts the clear sequence at
    // register 1 and drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= ADDR_W'(1);
            rw_q    <= '0;
            di_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b1;
            grant_q <= 1'b0;
`ifdef RFWB_ROUND_ROBIN_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            di_q    <= di_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
`ifdef RFWB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign Rw    = rw_q;
    assign Di    = di_q;
    assign WE    = we_q;
    assign busy  = busy_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed testbench for rf_wb_arbiter. A behavioural model tracks how many
// edges have elapsed since reset release and which requester must win, and
// a compare process checks every DUT output against it on each falling
// edge. Directed sequences add literal expectations at key points.
// Build option RFWB_ROUND_ROBIN_EN switches the model and the tie test to
// round-robin arbitration.

module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rw;
    logic [DATA_W-1:0] req0_di;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rw;
    logic [DATA_W-1:0] req1_di;
    logic              req1_ready;
    logic [ADDR_W-1:0] Rw;
    logic [DATA_W-1:0] Di;
    logic              WE;
    logic              busy;
    logic              grant;

    int testsRun    = 0;
    int testsFailed = 0;
    bit cmpOn       = 1'b0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREG  (NREG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_rw   (req0_rw),
        .req0_di   (req0_di),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rw   (req1_rw),
        .req1_di   (req1_di),
        .req1_ready(req1_ready),
        .Rw        (Rw),
        .Di        (Di),
        .WE        (WE),
        .busy      (busy),
        .grant     (grant)
    );

    // Model state: edges since reset release plus the expected port values.
    int                mEdges;
    logic              mWe;
    logic [ADDR_W-1:0] mRw;
    logic [DATA_W-1:0] mDi;
    logic              mBusy;
    logic              mGrant;
`ifdef RFWB_ROUND_ROBIN_EN
    int                mLast;
`endif

    // Which requester must be accepted right now (-1 for none).
    function automatic int winnerNow();
        int w;
        w = -1;
        if (reset === 1'b1 && mEdges >= NREG - 1) begin
            if (req0_valid && req1_valid) begin
`ifdef RFWB_ROUND_ROBIN_EN
                w = 1 - mLast;
`else
                w = 0;
`endif
            end else if (req0_valid) begin
                w = 0;
            end else if (req1_valid) begin
                w = 1;
            end
        end
        return w;
    endfunction

    // Model update: the first NREG-1 edges write zero to registers 1..NREG-1,
    // afterwards each edge publishes the accepted request, if any.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mEdges = 0;
            mWe    = 1'b0;
            mRw    = '0;
            mDi    = '0;
            mBusy  = 1'b1;
            mGrant = 1'b0;
`ifdef RFWB_ROUND_ROBIN_EN
            mLast  = 1;
`endif
        end else if (mEdges < NREG - 1) begin
            mEdges = mEdges + 1;
            mWe    = 1'b1;
            mRw    = ADDR_W'(mEdges);
            mDi    = '0;
            mBusy  = (mEdges < NREG - 1);
        end else begin
            int w;
            logic [ADDR_W-1:0] wr;
            w   = winnerNow();
            mWe = 1'b0;
            if (w >= 0) begin
                mGrant = (w == 1);
`ifdef RFWB_ROUND_ROBIN_EN
                mLast  = w;
`endif
                wr = (w == 1) ? req1_rw : req0_rw;
                if (wr != '0) begin
                    mWe = 1'b1;
                    mRw = wr;
                    mDi = (w == 1) ? req1_di : req0_di;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model away from the edge.
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("model_ready0", 32'(req0_ready), 32'(winnerNow() == 0));
            checkOutput("model_ready1", 32'(req1_ready), 32'(winnerNow() == 1));
            checkOutput("model_we",     32'(WE),         32'(mWe));
            checkOutput("model_rw",     32'(Rw),         32'(mRw));
            checkOutput("model_di",     Di,              mDi);
            checkOutput("model_busy",   32'(busy),       32'(mBusy));
            checkOutput("model_grant",  32'(grant),      32'(mGrant));
        end
    end

    task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] rw0,
                                 input logic [DATA_W-1:0] di0, input logic v1,
                                 input logic [ADDR_W-1:0] rw1,
                                 input logic [DATA_W-1:0] di1);
        req0_valid = v0;
        req0_rw    = rw0;
        req0_di    = di0;
        req1_valid = v1;
        req1_rw    = rw1;
        req1_di    = di1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the clear sequence to finish.
    task automatic waitClear();
        int n;
        n = 0;
        while (busy && n < 40) begin
            waitEdge();
            n++;
        end
        checkOutput("clear_timeout_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        reset = 1'b0;
        cmpOn = 1'b1;
        repeat (2) waitEdge();

        // Reset values.
        checkOutput("rst_we",    32'(WE),    32'd0);
        checkOutput("rst_rw",    32'(Rw),    32'd0);
        checkOutput("rst_di",    Di,         32'd0);
        checkOutput("rst_busy",  32'(busy),  32'd1);
        checkOutput("rst_grant", 32'(grant), 32'd0);

        // Clear sequence after release.
        reset = 1'b1;
        waitEdge();
        checkOutput("clr_first_rw",   32'(Rw),   32'd1);
        checkOutput("clr_first_we",   32'(WE),   32'd1);
        checkOutput("clr_first_busy", 32'(busy), 32'd1);
        repeat (29) waitEdge();
        checkOutput("clr_30_rw",   32'(Rw),   32'd30);
        checkOutput("clr_30_busy", 32'(busy), 32'd1);
        waitEdge();
        checkOutput("clr_last_rw",   32'(Rw),   32'd31);
        checkOutput("clr_last_we",   32'(WE),   32'd1);
        checkOutput("clr_last_busy", 32'(busy), 32'd0);
        waitEdge();
        checkOutput("clr_done_we", 32'(WE), 32'd0);

        // Single req0 write.
        applyStimulus(1'b1, 5'd2, 32'd5, 1'b0, '0, '0);
        #1;
        checkOutput("single_ready0", 32'(req0_ready), 32'd1);
        checkOutput("single_ready1", 32'(req1_ready), 32'd0);
        waitEdge();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("single_rw",    32'(Rw),    32'd2);
        checkOutput("single_di",    Di,         32'd5);
        checkOutput("single_we",    32'(WE),    32'd1);
        checkOutput("single_grant", 32'(grant), 32'd0);
        waitEdge();
        checkOutput("single_idle_we", 32'(WE), 32'd0);

        // Both requesters valid.
        applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd4, 32'd9);
`ifdef RFWB_ROUND_ROBIN_EN
        // req0 was granted last, so req1 leads the alternation.
        for (int i = 0; i < 4; i++) begin
            waitEdge();
            checkOutput("rr_grant", 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        waitEdge();
`else
        #1;
        checkOutput("both_ready0", 32'(req0_ready), 32'd1);
        checkOutput("both_ready1", 32'(req1_ready), 32'd0);
        waitEdge();
        applyStimulus(1'b0, 5'd3, 32'd7, 1'b1, 5'd4, 32'd9);
        checkOutput("both_first_rw",    32'(Rw),    32'd3);
        checkOutput("both_first_di",    Di,         32'd7);
        checkOutput("both_first_grant", 32'(grant), 32'd0);
        #1;
        checkOutput("both_second_ready1", 32'(req1_ready), 32'd1);
        waitEdge();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("both_second_rw",    32'(Rw),    32'd4);
        checkOutput("both_second_di",    Di,         32'd9);
        checkOutput("both_second_we",    32'(WE),    32'd1);
        checkOutput("both_second_grant", 32'(grant), 32'd1);
        waitEdge();
`endif

        // Write to register 0 is acknowledged but dropped.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        checkOutput("r0_ready1", 32'(req1_ready), 32'd1);
        waitEdge();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("r0_grant", 32'(grant), 32'd1);
        checkOutput("r0_we",    32'(WE),    32'd0);

        // Reset during CLEAR at Rw=10.
        reset = 1'b0;
        #1;
        checkOutput("rst_run_we",   32'(WE),   32'd0);
        checkOutput("rst_run_busy", 32'(busy), 32'd1);
        waitEdge();
        reset = 1'b1;
        repeat (10) waitEdge();
        checkOutput("mid_clr_rw", 32'(Rw), 32'd10);
        reset = 1'b0;
        #1;
        checkOutput("mid_clr_rst_rw",   32'(Rw),   32'd0);
        checkOutput("mid_clr_rst_we",   32'(WE),   32'd0);
        checkOutput("mid_clr_rst_busy", 32'(busy), 32'd1);
        waitEdge();
        reset = 1'b1;
        waitEdge();
        checkOutput("restart_rw", 32'(Rw), 32'd1);
        checkOutput("restart_we", 32'(WE), 32'd1);
        waitClear();

        // Reset during RUN with req0 pending; req0 keeps presenting.
        applyStimulus(1'b1, 5'd6, 32'd11, 1'b0, '0, '0);
        #1;
        checkOutput("pend_ready0", 32'(req0_ready), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("pend_rst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("pend_rst_we",     32'(WE),         32'd0);
        checkOutput("pend_rst_rw",     32'(Rw),         32'd0);
        checkOutput("pend_rst_busy",   32'(busy),       32'd1);
        waitEdge();
        reset = 1'b1;
        waitEdge();
        checkOutput("pend_clear_ready0", 32'(req0_ready), 32'd0);
        waitClear();
        checkOutput("pend_after_ready0", 32'(req0_ready), 32'd1);
        waitEdge();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("pend_rw",    32'(Rw),    32'd6);
        checkOutput("pend_di",    Di,         32'd11);
        checkOutput("pend_we",    32'(WE),    32'd1);
        checkOutput("pend_grant", 32'(grant), 32'd0);
        waitEdge();
        checkOutput("pend_idle_we", 32'(WE), 32'd0);

        @(negedge clk);
        cmpOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
